seq_pattern_gen: RTL
====================

# seq_pattern_gen

Bit-serial pattern transmitter. It loads a parallel pattern on a start request and shifts it out MSB-first on a single serial line, one bit per clock. It can repeat the frame a programmed number of times, with a fixed idle gap between repetitions. It is the stimulus/transmit end of the serial sequence-detector path: its `dout`/`valid` pair drives a detector's serial `in`.

## Interface
- `WIDTH`, 8: maximum pattern length in bits (≥2).
- `CNT_W`, 4: width of the repeat count.
- `GAP`, 2: idle cycles inserted between repetitions (0 allowed).
- `LEN_W`, $clog2(WIDTH+1): width of `len` (derived).

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `start` in 1: request to send. Sampled only in IDLE.
- `pattern` in WIDTH: frame bits. The `len` LSBs are sent, MSB of that field first.
- `len` in LEN_W: bits per frame. 0 or >WIDTH means WIDTH.
- `repeat_n` in CNT_W: extra repetitions. Total frames = `repeat_n`+1.
- `dout` out 1: serial data. 0 whenever `valid`=0.
- `valid` out 1: `dout` carries a frame bit.
- `busy` out 1: high from the cycle after start acceptance through the last bit.
- `done` out 1: one-cycle pulse after the final bit of the final frame.

## Operation
- FSM states: IDLE, SHIFT, GAP.
- IDLE:
  - `start`=1 at an edge captures `pattern`, effective `len` (L) and `repeat_n` (R) into internal registers, loads the bit index to L-1, and moves to SHIFT.
  - Inputs are ignored afterwards until the return to IDLE.
- SHIFT:
  - Each cycle drives `dout`=captured_pattern[idx] with `valid`=1, then decrements idx.
  - On idx=0 with frames remaining: go to GAP if GAP>0, otherwise reload idx=L-1 and stay in SHIFT, so frames run back-to-back.
  - On idx=0 with no frames remaining: go to IDLE and pulse `done`.
- GAP:
  - `dout`=0, `valid`=0, `busy`=1 for exactly GAP cycles.
  - Then reload idx=L-1, decrement the remaining-frame count, and return to SHIFT.
- `start` while busy is ignored, with no queueing.
- `start` in the cycle `done` is high is accepted, because the FSM is already in IDLE.
- Changes to `pattern`, `len` or `repeat_n` while busy have no effect.
- Repeat counter:
  - CNT_W bits, loaded with R, decremented at each frame end.
  - A frame is the last one when the counter is 0.
  - No wrap: R=2^CNT_W-1 gives exactly 2^CNT_W frames.

## Timing
- All outputs are registered.
- Reset values: `dout`=0, `valid`=0, `busy`=0, `done`=0, state IDLE, all counters 0.
- `rst` low forces all outputs to their reset values immediately, asynchronously, including mid-frame or mid-gap.
- After `rst` rises, the first edge at which `start` can be accepted is the next rising edge.
- Start accepted at edge k:
  - First bit appears after edge k+1 and is valid during cycle k+1.
  - Busy duration = (R+1)·L + R·GAP cycles.
  - `done` is high for the single cycle immediately following the last `valid` bit.
  - `busy` and `valid` are low in that `done` cycle.
- Minimum spacing between consecutive frames when restarting through IDLE: one non-valid cycle (the `done` cycle).
- L=1 is legal: each frame is one valid cycle.

## Structure
- Shared package `seq_gen_pkg` holds:
  - the state enum (IDLE=2'b00, SHIFT=2'b01, GAP=2'b10);
  - the default `WIDTH`, `CNT_W` and `GAP` constants.
- The unused state encoding 2'b11 recovers to IDLE with outputs cleared.
- Natural sub-module: `seq_bit_counter`, a loadable down-counter with a zero flag. Instantiate it twice: once for the bit index (LEN_W) and once for the repeat count (CNT_W).
- The FSM and output registers live in the top module.

## Test plan
- `pattern`=8'b1101_0110, `len`=8, `repeat_n`=0, one `start` pulse:
  - `dout` = 1,1,0,1,0,1,1,0 over 8 cycles with `valid`=1;
  - `done`=1 in cycle 9;
  - `busy` high for exactly 8 cycles.
- `pattern`=8'b0000_0101, `len`=3 → `dout` 1,0,1. With `len`=0 → all 8 bits 0,0,0,0,0,1,0,1.
- `pattern`=8'b0000_0011, `len`=2, `repeat_n`=2, GAP=2:
  - `valid` sequence 1,1,0,0,1,1,0,0,1,1;
  - `busy` high for 10 cycles, then one `done` pulse.
- `start` asserted again at cycle 3 of a frame, with a different `pattern`: output is unchanged and no second frame follows. `start` held high through `done`: a new frame starts with exactly one gap cycle.
- Drive `rst`=0 asynchronously, between clock edges, during bit 4 of an 8-bit frame:
  - `dout`, `valid`, `busy` and `done` go to 0 immediately;
  - after release, a new `start` sends a full frame from its MSB.
- `repeat_n`=4'hF, `len`=2, GAP=0: 16 back-to-back frames, 32 contiguous `valid` cycles, a single `done`.

Source files
------------

// File: rtl/seq_gen_pkg.sv
// Shared types and default sizing for the serial pattern transmitter.
package seq_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_GAP   = 2'b10
    } state_e;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_CNT_W = 4;
    localparam int DEF_GAP   = 2;

endpackage

// File: rtl/seq_bit_counter.sv
// Loadable down-counter that saturates at zero and flags the zero value.
module seq_bit_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic [W-1:0] cnt_o,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

    assign cnt_o  = cnt_q;
    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/seq_pattern_gen.sv
// Bit-serial pattern transmitter: captures a pattern on start and shifts it out
// MSB-first, optionally repeating the frame with a fixed idle gap in between.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | waiting for start; emits the done pulse after a run
// ST_SHIFT | driving one frame bit per cycle, valid=1
// ST_GAP   | idle gap between repeated frames, busy=1, valid=0
module seq_pattern_gen
    import seq_gen_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W,
    parameter int GAP   = DEF_GAP,
    parameter int LEN_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] pattern,
    input  logic [LEN_W-1:0] len,
    input  logic [CNT_W-1:0] repeat_n,
    output logic             dout,
    output logic             valid,
    output logic             busy,
    output logic             done
);

    localparam int GAP_W = (GAP > 1) ? $clog2(GAP + 1) : 1;

    state_e             state_q;
    logic [WIDTH-1:0]   pat_q;
    logic [LEN_W-1:0]   len_q;
    logic [GAP_W-1:0]   gap_q;
    logic               dout_q;
    logic               valid_q;
    logic               busy_q;
    logic               done_q;
    logic               done_pend_q;

    logic [LEN_W-1:0]   len_eff;
    logic               idx_load;
    logic [LEN_W-1:0]   idx_val;
    logic               idx_dec;
    logic [LEN_W-1:0]   idx_cnt;
    logic               idx_zero;
    logic               rep_load;
    logic               rep_dec;
    logic [CNT_W-1:0]   rep_cnt;
    logic               rep_zero;
    logic               cur_bit;

    // Out-of-range lengths fall back to the full pattern width.
    assign len_eff = ((len == '0) || (len > LEN_W'(WIDTH))) ? LEN_W'(WIDTH) : len;
    assign cur_bit = |(pat_q & (WIDTH'(1) << idx_cnt));

    seq_bit_counter #(.W(LEN_W)) u_idx_cnt (
        .clk        (clk),
        .rst        (rst),
        .load_i     (idx_load),
        .load_val_i (idx_val),
        .dec_i      (idx_dec),
        .cnt_o      (idx_cnt),
        .zero_o     (idx_zero)
    );

    seq_bit_counter #(.W(CNT_W)) u_rep_cnt (
        .clk        (clk),
        .rst        (rst),
        .load_i     (rep_load),
        .load_val_i (repeat_n),
        .dec_i      (rep_dec),
        .cnt_o      (rep_cnt),
        .zero_o     (rep_zero)
    );

    always_comb begin
        idx_load = 1'b0;
        idx_val  = len_q - LEN_W'(1);
        idx_dec  = 1'b0;
        rep_load = 1'b0;
        rep_dec  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    idx_load = 1'b1;
                    idx_val  = len_eff - LEN_W'(1);
                    rep_load = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (!idx_zero) begin
                    idx_dec = 1'b1;
                end else if (rep_cnt != '0) begin
                    rep_dec = 1'b1;
                    if (GAP == 0) begin
                        idx_load = 1'b1;
                    end
                end
            end
            ST_GAP: begin
                if (gap_q == '0) begin
                    idx_load = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            pat_q       <= '0;
            len_q       <= '0;
            gap_q       <= '0;
            dout_q      <= 1'b0;
            valid_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            done_pend_q <= 1'b0;
        end else begin
            dout_q  <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    // done trails the last valid bit by one cycle
                    done_q      <= done_pend_q;
                    done_pend_q <= 1'b0;
                    if (start) begin
                        pat_q   <= pattern;
                        len_q   <= len_eff;
                        state_q <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    dout_q  <= cur_bit;
                    valid_q <= 1'b1;
                    busy_q  <= 1'b1;
                    if (idx_zero) begin
                        if (rep_zero) begin
                            state_q     <= ST_IDLE;
                            done_pend_q <= 1'b1;
                        end else if (GAP > 0) begin
                            state_q <= ST_GAP;
                            gap_q   <= GAP_W'(GAP - 1);
                        end
                    end
                end
                ST_GAP: begin
                    busy_q <= 1'b1;
                    if (gap_q == '0) begin
                        state_q <= ST_SHIFT;
                    end else begin
                        gap_q <= gap_q - GAP_W'(1);
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    done_pend_q <= 1'b0;
                end
            endcase
        end
    end

    assign dout  = dout_q;
    assign valid = valid_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule
